// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - control, song ROM and playback signals of the song sequencer
interface song_sequencer_if #(
  parameter int ADDR_W   = 8,
  parameter int PERIOD_W = 27
);
  logic                start;
  logic                stop;
  logic                pause;
  logic [PERIOD_W-1:0] beat_period;
  logic [ADDR_W-1:0]   rom_addr;
  logic [7:0]          rom_data;
  logic [3:0]          note;
  logic                note_valid;
  logic                beat_tick;
  logic                busy;
  logic                done;

  // master is the sequencer itself; slave is the controller plus song ROM around it
  modport master (
    input  start, stop, pause, beat_period, rom_data,
    output rom_addr, note, note_valid, beat_tick, busy, done
  );

  modport slave (
    output start, stop, pause, beat_period, rom_data,
    input  rom_addr, note, note_valid, beat_tick, busy, done
  );
endinterface

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - steps through a note ROM, holding each note for duration x beat_period cycles
module song_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int PERIOD_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  song_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  localparam logic [PERIOD_W-1:0] ONE_P = {{(PERIOD_W-1){1'b0}}, 1'b1};

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr, addr_nx;
  logic [PERIOD_W-1:0] period, period_nx;
  logic [PERIOD_W-1:0] timer, timer_nx;
  logic [3:0]          note, note_nx;
  logic [3:0]          beats_left, beats_nx;
  logic                note_valid, note_valid_nx;
  logic                busy, busy_nx;
  logic                done, done_nx;
  logic                tick_due;

  assign tick_due = (timer == (period - ONE_P));

  assign bus.rom_addr   = addr;
  assign bus.note       = note;
  assign bus.note_valid = note_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.beat_tick  = (state == S_PLAY) && !bus.pause && !bus.stop && tick_due;

  always_comb begin
    state_nx      = state;
    addr_nx       = addr;
    period_nx     = period;
    timer_nx      = timer;
    note_nx       = note;
    beats_nx      = beats_left;
    note_valid_nx = note_valid;

    if (bus.stop) begin
      state_nx      = S_IDLE;
      addr_nx       = '0;
      timer_nx      = '0;
      note_nx       = 4'd0;
      beats_nx      = 4'd0;
      note_valid_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_nx = '0;
          if (bus.start) begin
            // a zero period would never tick; run it as one cycle per beat
            period_nx = (bus.beat_period == '0) ? ONE_P : bus.beat_period;
            state_nx  = S_FETCH;
          end
        end
        S_FETCH: begin
          state_nx = S_LOAD;
        end
        S_LOAD: begin
          if (bus.rom_data[3:0] == 4'd0) begin
            state_nx      = S_DONE;
            note_nx       = 4'd0;
            note_valid_nx = 1'b0;
          end else begin
            state_nx      = S_PLAY;
            note_nx       = bus.rom_data[7:4];
            note_valid_nx = (bus.rom_data[7:4] != 4'd0);
            beats_nx      = bus.rom_data[3:0];
            timer_nx      = '0;
          end
        end
        S_PLAY: begin
          if (!bus.pause) begin
            if (tick_due) begin
              timer_nx = '0;
              beats_nx = beats_left - 4'd1;
              if (beats_left == 4'd1) begin
                // address wraps naturally past the top of the ROM
                addr_nx       = addr + 1'b1;
                state_nx      = S_FETCH;
                note_valid_nx = 1'b0;
              end
            end else begin
              timer_nx = timer + ONE_P;
            end
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
          addr_nx  = '0;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end

    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      period     <= '0;
      timer      <= '0;
      note       <= 4'd0;
      beats_left <= 4'd0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      period     <= period_nx;
      timer      <= timer_nx;
      note       <= note_nx;
      beats_left <= beats_nx;
      note_valid <= note_valid_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed bench for song_sequencer with hand-computed expectations
module tb_song_sequencer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  int   u;

  logic [7:0] rom_a [256];
  logic [7:0] rom_b [4];

  song_sequencer_if #(.ADDR_W(8), .PERIOD_W(27)) ifa ();
  song_sequencer_if #(.ADDR_W(2), .PERIOD_W(27)) ifb ();

  song_sequencer #(.ADDR_W(8), .PERIOD_W(27)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  song_sequencer #(.ADDR_W(2), .PERIOD_W(27)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous song ROMs: data valid the cycle after the address
  always @(posedge clk) ifa.rom_data <= rom_a[ifa.rom_addr];
  always @(posedge clk) ifb.rom_data <= rom_b[ifb.rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FETCH then LOAD: two silent busy cycles
  task automatic gap_a(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_gap_valid"}, 32'(ifa.note_valid), 32'd0);
      chk({tag, "_gap_busy"},  32'(ifa.busy),       32'd1);
      chk({tag, "_gap_tick"},  32'(ifa.beat_tick),  32'd0);
      step();
    end
  endtask

  task automatic play_a(input string tag, input int pitch, input int valid, input int n, input int p);
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_note"},  32'(ifa.note),       32'(pitch));
      chk({tag, "_valid"}, 32'(ifa.note_valid), 32'(valid));
      chk({tag, "_tick"},  32'(ifa.beat_tick),  ((i % p) == 0) ? 32'd1 : 32'd0);
      chk({tag, "_done"},  32'(ifa.done),       32'd0);
      step();
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int k = 0; k < 256; k++) rom_a[k] = 8'h00;
    for (int k = 0; k < 4; k++) rom_b[k] = 8'h11;
    reset = 1'b0;
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.pause = 1'b0; ifa.beat_period = 27'd0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.pause = 1'b0; ifb.beat_period = 27'd0;

    // reset state
    step();
    chk("rst_addr",  32'(ifa.rom_addr),   32'd0);
    chk("rst_note",  32'(ifa.note),       32'd0);
    chk("rst_valid", 32'(ifa.note_valid), 32'd0);
    chk("rst_tick",  32'(ifa.beat_tick),  32'd0);
    chk("rst_busy",  32'(ifa.busy),       32'd0);
    chk("rst_done",  32'(ifa.done),       32'd0);
    reset = 1'b1;
    step();

    // P=4, {0x32, 0x51, 0x00}
    rom_a[0] = 8'h32; rom_a[1] = 8'h51; rom_a[2] = 8'h00;
    step();
    ifa.beat_period = 27'd4; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    chk("s1_busy_fetch", 32'(ifa.busy), 32'd1);
    gap_a("s1a");
    play_a("s1_n3", 3, 1, 8, 4);
    gap_a("s1b");
    play_a("s1_n5", 5, 1, 4, 4);
    gap_a("s1c");
    chk("s1_done",      32'(ifa.done), 32'd1);
    chk("s1_done_busy", 32'(ifa.busy), 32'd1);
    step();
    chk("s1_idle_done", 32'(ifa.done),     32'd0);
    chk("s1_idle_busy", 32'(ifa.busy),     32'd0);
    chk("s1_idle_addr", 32'(ifa.rom_addr), 32'd0);

    // P=3, rest then note 7
    rom_a[0] = 8'h02; rom_a[1] = 8'h71; rom_a[2] = 8'h00;
    step();
    ifa.beat_period = 27'd3; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    gap_a("s2a");
    play_a("s2_rest", 0, 0, 6, 3);
    gap_a("s2b");
    play_a("s2_n7", 7, 1, 3, 3);
    gap_a("s2c");
    chk("s2_done", 32'(ifa.done), 32'd1);
    step();
    chk("s2_idle_busy", 32'(ifa.busy), 32'd0);

    // P=5, pause for 7 cycles from PLAY cycle 3
    rom_a[0] = 8'h92; rom_a[1] = 8'h00;
    step();
    ifa.beat_period = 27'd5; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    gap_a("s3a");
    u = 0;
    for (int i = 1; i <= 17; i++) begin
      ifa.pause = (i >= 3) && (i <= 9);
      #1;
      if (!ifa.pause) u++;
      chk("s3_note",  32'(ifa.note),       32'd9);
      chk("s3_valid", 32'(ifa.note_valid), 32'd1);
      chk("s3_tick",  32'(ifa.beat_tick),  (!ifa.pause && (u % 5) == 0) ? 32'd1 : 32'd0);
      step();
    end
    ifa.pause = 1'b0;
    gap_a("s3b");
    chk("s3_done", 32'(ifa.done), 32'd1);
    step();
    chk("s3_idle_busy", 32'(ifa.busy), 32'd0);

    // P=10, stop with start and pause mid-note
    rom_a[0] = 8'h34; rom_a[1] = 8'h00;
    step();
    ifa.beat_period = 27'd10; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    gap_a("s4a");
    play_a("s4_n3", 3, 1, 5, 10);
    ifa.stop = 1'b1; ifa.start = 1'b1; ifa.pause = 1'b1;
    step();
    ifa.stop = 1'b0; ifa.start = 1'b0; ifa.pause = 1'b0;
    chk("s4_busy",  32'(ifa.busy),       32'd0);
    chk("s4_valid", 32'(ifa.note_valid), 32'd0);
    chk("s4_addr",  32'(ifa.rom_addr),   32'd0);
    chk("s4_note",  32'(ifa.note),       32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("s4_nodone", 32'(ifa.done), 32'd0);
      chk("s4_idle",   32'(ifa.busy), 32'd0);
      step();
    end

    // ADDR_W=2, all 0x11, P=1: address wraps and playback never ends
    ifb.beat_period = 27'd1; ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      chk("s5_fetch_addr", 32'(ifb.rom_addr),   32'(n % 4));
      chk("s5_fetch_done", 32'(ifb.done),       32'd0);
      step();
      chk("s5_load_valid", 32'(ifb.note_valid), 32'd0);
      step();
      chk("s5_play_addr",  32'(ifb.rom_addr),   32'(n % 4));
      chk("s5_play_note",  32'(ifb.note),       32'd1);
      chk("s5_play_valid", 32'(ifb.note_valid), 32'd1);
      chk("s5_play_tick",  32'(ifb.beat_tick),  32'd1);
      step();
    end
    ifb.stop = 1'b1;
    step();
    ifb.stop = 1'b0;
    chk("s5_stop_busy", 32'(ifb.busy), 32'd0);

    // asynchronous reset mid-PLAY, then replay with a new period
    step();
    ifa.beat_period = 27'd4; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    gap_a("s6a");
    play_a("s6_pre", 3, 1, 3, 4);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_rst_note",  32'(ifa.note),       32'd0);
    chk("s6_rst_valid", 32'(ifa.note_valid), 32'd0);
    chk("s6_rst_tick",  32'(ifa.beat_tick),  32'd0);
    chk("s6_rst_busy",  32'(ifa.busy),       32'd0);
    chk("s6_rst_done",  32'(ifa.done),       32'd0);
    chk("s6_rst_addr",  32'(ifa.rom_addr),   32'd0);
    step();
    chk("s6_rst_hold", 32'(ifa.busy), 32'd0);
    reset = 1'b1;
    step();
    ifa.beat_period = 27'd2; ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    ifa.beat_period = 27'd7;
    gap_a("s6b");
    play_a("s6_n3", 3, 1, 8, 2);
    gap_a("s6c");
    chk("s6_done", 32'(ifa.done), 32'd1);
    step();
    chk("s6_idle_busy", 32'(ifa.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Plays a stored song by stepping through a note ROM and holding each note for a programmable number of beats. Owns the beat-interval timer (the programmable tick counter) and sequences it: latches the beat period, restarts the timer per note, and counts beats down. Sits between the song ROM and the pitch/scoring logic. Supports start, pause, stop, and a terminator entry.

## Interface
- ADDR_W, 8, song ROM address width
- PERIOD_W, 27, beat-period width (cycles per beat)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- start  in  1  level sampled in IDLE; begins playback at address 0
- stop  in  1  synchronous abort to IDLE; highest priority
- pause  in  1  freezes timer and beat count while high (PLAY only)
- beat_period  in  PERIOD_W  cycles per beat, latched on start
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  8  ROM entry, valid the cycle after rom_addr is presented; [7:4] pitch, [3:0] duration in beats
- note  out  4  current pitch (0 = rest)
- note_valid  out  1  high in PLAY when pitch != 0
- beat_tick  out  1  one-cycle pulse at each beat boundary in PLAY
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on reaching terminator

## Operation
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE: rom_addr=0. start=1 → latch P=beat_period (P==0 treated as 1), go FETCH.
- FETCH: rom_addr presented → LOAD.
- LOAD: rom_data valid. Duration 0 → DONE. Otherwise note←pitch, beats_left←duration, timer←0 → PLAY.
- PLAY: timer increments each unpaused cycle. At timer==P-1: beat_tick=1, timer←0, beats_left−1. On the tick where beats_left==1: rom_addr+1 → FETCH.
- DONE: done=1 for one cycle → IDLE, rom_addr←0.
- Rest entries (pitch 0): timed like notes, with note_valid=0.
- Address wrap: a non-terminator at address 2^ADDR_W−1 increments to 0 and playback continues.
- pause: timer, beats_left and note frozen; note_valid unchanged; no beat_tick. In FETCH/LOAD, pause is ignored.
- stop: any state → IDLE next edge. Clears note, note_valid, timer, rom_addr; no done pulse. Overrides start and pause in the same cycle.
- start while busy: ignored. Changes to beat_period while busy: ignored until the next start.

## Timing
- Reset values: rom_addr=0, note=0, note_valid=0, beat_tick=0, busy=0, done=0, state IDLE.
- Outputs are registered, except beat_tick, which is decoded from registered state.
- start sampled at edge k: FETCH from k, LOAD from k+1, PLAY with note_valid from k+2.
- A note of duration D occupies exactly D·P unpaused PLAY cycles. Its last cycle carries the final beat_tick.
- Articulation gap: 2 cycles (FETCH, LOAD) between notes, with note_valid=0.
- Terminator: done pulses 2 cycles after the previous note's last PLAY cycle (FETCH, LOAD, then DONE). busy drops the following cycle.
- P==1: beat_tick is high every PLAY cycle.
- Asynchronous reset mid-note: all outputs are zero immediately; no done pulse.

## Test plan
- P=4; ROM {0x32, 0x51, 0x00}; start pulse.
  - Required: note=3 with note_valid for 8 cycles, ticks on cycles 4 and 8, then 2-cycle gap.
  - Then note=5 for 4 cycles, then done pulses once and busy drops.
- P=3; ROM {0x02, 0x71, 0x00}.
  - Required: 6 cycles of note_valid=0 with 2 beat_ticks, then note=7 for 3 cycles.
- P=5; ROM {0x92, 0x00}; hold pause high for 7 cycles starting at PLAY cycle 3.
  - Required: note=9 for 17 cycles total, no beat_tick while paused, ticks resume on schedule.
- P=10 mid-note: assert stop together with start and pause.
  - Required: IDLE next edge; note_valid, rom_addr and busy are 0; no done pulse.
- ADDR_W=2; ROM all 0x11.
  - Required: rom_addr sequence 0,1,2,3,0,1…; playback continues; done never pulses.
- Assert reset (low) mid-PLAY.
  - Required: all outputs are 0 asynchronously.
  - After release, start replays from address 0 with the newly latched beat_period.
